// File: rtl/spm_layer_pkg.sv
// Shared definitions for the scalar-product layer: FSM states, activation
// encodings and width helpers used by the top level and the activation stage.
package spm_layer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_A,
        ST_COMPUTE,
        ST_OUTPUT
    } state_t;

    localparam int ACT_IDENTITY = 0;
    localparam int ACT_RELU     = 1;

    // Wide enough that summing n_inputs full-scale products can never wrap.
    function automatic int acc_width(input int data_w, input int n_inputs);
        return 2 * data_w + $clog2(n_inputs);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spm_act.sv
// Activation stage: arithmetic shift, optional ReLU, then saturation of a
// wide accumulator down to a DATA_W signed word. Purely combinational.
module spm_act
    import spm_layer_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 33,
    parameter int FRAC_BITS = 0,
    parameter int ACT_MODE  = ACT_RELU
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] result
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] shifted;

    assign acc_s = acc;

    always_comb begin
        shifted = acc_s >>> FRAC_BITS;
        if (ACT_MODE == ACT_RELU && shifted[ACC_W-1]) begin
            shifted = '0;
        end
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/spm_layer.sv
// Serial-input neural layer: loads a weight frame and an activation frame,
// runs one MAC per cycle for every neuron, then streams activated results.
module spm_layer
    import spm_layer_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int N_NEURONS = 3,
    parameter int N_INPUTS  = 2,
    parameter int FRAC_BITS = 0,
    parameter int ACT_MODE  = ACT_RELU
) (
    input  logic                              clk,
    input  logic                              areset,
    input  logic                              i_valid,
    input  logic                              i_wsel,
    input  logic [DATA_W-1:0]                 i_value,
    output logic                              i_ready,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic [idx_width(N_NEURONS)-1:0]   o_index,
    output logic [DATA_W-1:0]                 o_result,
    output logic                              o_busy
);

    localparam int ACC_W   = acc_width(DATA_W, N_INPUTS);
    localparam int N_TOTAL = N_NEURONS * N_INPUTS;
    localparam int E_W     = idx_width(N_TOTAL);
    localparam int K_W     = idx_width(N_INPUTS);
    localparam int N_W     = idx_width(N_NEURONS);
    localparam int P_W     = 2 * DATA_W;

    localparam logic [E_W-1:0] E_LAST_W = E_W'(N_TOTAL - 1);
    localparam logic [E_W-1:0] E_LAST_A = E_W'(N_INPUTS - 1);
    localparam logic [K_W-1:0] K_LAST   = K_W'(N_INPUTS - 1);
    localparam logic [N_W-1:0] N_LAST   = N_W'(N_NEURONS - 1);

    state_t                  state;
    logic [E_W-1:0]          elem_cnt;
    logic [K_W-1:0]          k_cnt;
    logic [N_W-1:0]          n_cnt;
    logic signed [DATA_W-1:0] weights [N_TOTAL];
    logic signed [DATA_W-1:0] acts    [N_INPUTS];
    logic signed [ACC_W-1:0]  acc     [N_NEURONS];

    logic signed [P_W-1:0]   w_ext;
    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   product;
    logic [ACC_W-1:0]        out_acc;

    // elem_cnt doubles as the flat weight index during COMPUTE (neuron-major).
    assign w_ext   = P_W'(weights[elem_cnt]);
    assign a_ext   = P_W'(acts[k_cnt]);
    assign product = w_ext * a_ext;

    assign i_ready = (state == ST_IDLE) || (state == ST_LOAD_W) || (state == ST_LOAD_A);
    assign o_busy  = (state != ST_IDLE);
    assign out_acc = acc[o_index];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= ST_IDLE;
            elem_cnt <= '0;
            k_cnt    <= '0;
            n_cnt    <= '0;
            o_valid  <= 1'b0;
            o_index  <= '0;
            for (int i = 0; i < N_TOTAL; i++) weights[i] <= '0;
            for (int i = 0; i < N_INPUTS; i++) acts[i] <= '0;
            for (int i = 0; i < N_NEURONS; i++) acc[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        if (i_wsel) begin
                            weights[0] <= i_value;
                            if (N_TOTAL > 1) begin
                                state    <= ST_LOAD_W;
                                elem_cnt <= E_W'(1);
                            end
                        end else begin
                            acts[0] <= i_value;
                            if (N_INPUTS > 1) begin
                                state    <= ST_LOAD_A;
                                elem_cnt <= E_W'(1);
                            end else begin
                                state <= ST_COMPUTE;
                                for (int i = 0; i < N_NEURONS; i++) acc[i] <= '0;
                            end
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (i_valid) begin
                        weights[elem_cnt] <= i_value;
                        if (elem_cnt == E_LAST_W) begin
                            elem_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            elem_cnt <= elem_cnt + E_W'(1);
                        end
                    end
                end
                ST_LOAD_A: begin
                    if (i_valid) begin
                        acts[elem_cnt[K_W-1:0]] <= i_value;
                        if (elem_cnt == E_LAST_A) begin
                            elem_cnt <= '0;
                            state    <= ST_COMPUTE;
                            for (int i = 0; i < N_NEURONS; i++) acc[i] <= '0;
                        end else begin
                            elem_cnt <= elem_cnt + E_W'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    acc[n_cnt] <= acc[n_cnt] + ACC_W'(product);
                    elem_cnt   <= elem_cnt + E_W'(1);
                    if (k_cnt == K_LAST) begin
                        k_cnt <= '0;
                        if (n_cnt == N_LAST) begin
                            n_cnt    <= '0;
                            elem_cnt <= '0;
                            state    <= ST_OUTPUT;
                            o_valid  <= 1'b1;
                            o_index  <= '0;
                        end else begin
                            n_cnt <= n_cnt + N_W'(1);
                        end
                    end else begin
                        k_cnt <= k_cnt + K_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (o_ready) begin
                        if (o_index == N_LAST) begin
                            o_valid <= 1'b0;
                            o_index <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            o_index <= o_index + N_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    spm_act #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .FRAC_BITS(FRAC_BITS),
        .ACT_MODE (ACT_MODE)
    ) u_act (
        .acc   (out_acc),
        .result(o_result)
    );

endmodule

// File: tb/tb_spm_layer.sv
// Bench for spm_layer: a ReLU and an identity instance share stimulus and are
// checked every cycle against an arithmetic model of the layer.
module tb_spm_layer;

    localparam int DATA_W    = 16;
    localparam int N         = 3;
    localparam int K         = 2;
    localparam int NK        = N * K;
    localparam int FRAC_BITS = 0;
    localparam int LAT       = NK + 1;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_wsel = 1'b0;
    logic [15:0] i_value = '0;
    logic        o_ready = 1'b1;

    logic        i_ready_r, o_valid_r, o_busy_r;
    logic [1:0]  o_index_r;
    logic [15:0] o_result_r;
    logic        i_ready_i, o_valid_i, o_busy_i;
    logic [1:0]  o_index_i;
    logic [15:0] o_result_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int model_w[NK];
    int model_a[K];
    int exp_idx[$];
    int exp_relu[$];
    int exp_id[$];
    int log_relu[$];
    int log_id[$];

    int last_acc_cyc = 0;
    bit timing_pending = 1'b0;
    bit rand_ready = 1'b0;
    int stall_left = 0;

    bit prev_valid = 1'b0;
    bit prev_stall = 1'b0;
    int held_idx = 0;
    int held_res = 0;

    spm_layer #(.DATA_W(DATA_W), .N_NEURONS(N), .N_INPUTS(K), .FRAC_BITS(FRAC_BITS), .ACT_MODE(1)) dut_relu (
        .clk(clk), .areset(areset), .i_valid(i_valid), .i_wsel(i_wsel), .i_value(i_value),
        .i_ready(i_ready_r), .o_valid(o_valid_r), .o_ready(o_ready), .o_index(o_index_r),
        .o_result(o_result_r), .o_busy(o_busy_r)
    );

    spm_layer #(.DATA_W(DATA_W), .N_NEURONS(N), .N_INPUTS(K), .FRAC_BITS(FRAC_BITS), .ACT_MODE(0)) dut_id (
        .clk(clk), .areset(areset), .i_valid(i_valid), .i_wsel(i_wsel), .i_value(i_value),
        .i_ready(i_ready_i), .o_valid(o_valid_i), .o_ready(o_ready), .o_index(o_index_i),
        .o_result(o_result_i), .o_busy(o_busy_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Neuron output straight from the layer's definition: dot product, shift,
    // optional ReLU, clamp to the signed 16-bit range.
    function automatic int ref_neuron(input int n, input int mode);
        longint acc = 0;
        for (int k = 0; k < K; k++) acc += longint'(model_w[n*K + k]) * longint'(model_a[k]);
        acc = acc >>> FRAC_BITS;
        if (mode == 1 && acc < 0) acc = 0;
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
    endfunction

    function automatic int rand_word();
        int r = $urandom_range(7, 0);
        if (r == 0) return 32767;
        if (r == 1) return -32768;
        return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    // Output consumer: random back-pressure or a forced stall window.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            o_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            o_ready = ($urandom_range(3, 0) != 0);
        end else begin
            o_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (areset) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (o_valid_r && exp_idx.size() == 0) checkOutput("spurious_valid_relu", o_valid_r, 0);
            if (o_valid_i && exp_idx.size() == 0) checkOutput("spurious_valid_id", o_valid_i, 0);
            if (timing_pending && cyc > last_acc_cyc && !o_valid_r) begin
                checkOutput("ready_low_compute", i_ready_r, 0);
                checkOutput("busy_compute", o_busy_r, 1);
            end
            if (o_valid_r && !prev_valid && timing_pending) begin
                checkOutput("first_valid_cycle", cyc - last_acc_cyc, LAT);
                timing_pending = 1'b0;
            end else if (timing_pending && cyc - last_acc_cyc > LAT) begin
                checkOutput("first_valid_missing", o_valid_r, 1);
                timing_pending = 1'b0;
            end
            if (prev_stall) begin
                checkOutput("hold_valid", o_valid_r, 1);
                checkOutput("hold_index", o_index_r, held_idx);
                checkOutput("hold_result", longint'($signed(o_result_r)), held_res);
            end
            if (o_valid_r) checkOutput("ready_low_output", i_ready_r, 0);
            if (o_valid_r && o_ready && exp_idx.size() > 0) begin
                checkOutput("index_relu", o_index_r, exp_idx[0]);
                checkOutput("result_relu", longint'($signed(o_result_r)), exp_relu[0]);
                checkOutput("valid_id", o_valid_i, 1);
                checkOutput("index_id", o_index_i, exp_idx[0]);
                checkOutput("result_id", longint'($signed(o_result_i)), exp_id[0]);
                log_relu.push_back(int'($signed(o_result_r)));
                log_id.push_back(int'($signed(o_result_i)));
                void'(exp_idx.pop_front());
                void'(exp_relu.pop_front());
                void'(exp_id.pop_front());
            end
            prev_valid = o_valid_r;
            prev_stall = o_valid_r && !o_ready;
            held_idx   = int'(o_index_r);
            held_res   = int'($signed(o_result_r));
        end
    end

    task automatic applyStimulus(input bit wsel, input int vals[NK], input int len,
                                 input int gap_max, input bit toggle);
        bit accepted;
        int budget;
        int gaps;
        for (int i = 0; i < len; i++) begin
            gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            repeat (gaps) begin
                i_valid = 1'b0;
                i_wsel  = 1'($urandom_range(1, 0));
                @(posedge clk); #1;
            end
            i_valid = 1'b1;
            i_value = 16'(vals[i]);
            i_wsel  = (i == 0) ? wsel : (toggle ? ~wsel : 1'($urandom_range(1, 0)));
            accepted = 1'b0;
            budget = 0;
            while (!accepted && budget < 100) begin
                @(negedge clk);
                accepted = i_ready_r;
                if (accepted && !wsel && i == len - 1) begin
                    for (int k = 0; k < K; k++) model_a[k] = vals[k];
                    for (int n = 0; n < N; n++) begin
                        exp_idx.push_back(n);
                        exp_relu.push_back(ref_neuron(n, 1));
                        exp_id.push_back(ref_neuron(n, 0));
                    end
                    last_acc_cyc   = cyc;
                    timing_pending = 1'b1;
                end
                @(posedge clk); #1;
                budget++;
            end
            if (!accepted) checkOutput("word_accept_timeout", 0, 1);
        end
        i_valid = 1'b0;
        if (wsel) for (int j = 0; j < NK; j++) model_w[j] = vals[j];
    endtask

    task automatic waitDrain();
        int b = 0;
        while ((exp_idx.size() != 0 || o_valid_r || timing_pending) && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (b >= 300) begin
            checkOutput("drain_timeout", 0, 1);
            exp_idx.delete(); exp_relu.delete(); exp_id.delete();
            timing_pending = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic checkLogs(input string name, input int r0, input int r1, input int r2,
                             input int d0, input int d1, input int d2);
        int er[3];
        int ed[3];
        er = '{r0, r1, r2};
        ed = '{d0, d1, d2};
        checkOutput({name, "_count"}, log_relu.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < log_relu.size()) checkOutput($sformatf("%s_relu%0d", name, i), log_relu[i], er[i]);
            if (i < log_id.size())   checkOutput($sformatf("%s_id%0d", name, i), log_id[i], ed[i]);
        end
        log_relu.delete();
        log_id.delete();
    endtask

    task automatic resetChecks(input string name);
        checkOutput({name, "_i_ready"}, i_ready_r, 1);
        checkOutput({name, "_o_valid"}, o_valid_r, 0);
        checkOutput({name, "_o_busy"}, o_busy_r, 0);
        checkOutput({name, "_o_index"}, o_index_r, 0);
        checkOutput({name, "_o_result"}, o_result_r, 0);
        checkOutput({name, "_id_busy"}, o_busy_i, 0);
        checkOutput({name, "_id_ready"}, i_ready_i, 1);
    endtask

    initial begin
        int w[NK];
        int a[NK];
        int b;
        for (int j = 0; j < NK; j++) model_w[j] = 0;

        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        resetChecks("reset");
        @(posedge clk); #1;

        w = '{1, 2, 3, 4, -5, 6};
        a = '{10, 20, 0, 0, 0, 0};
        applyStimulus(1'b1, w, NK, 0, 1'b0);
        applyStimulus(1'b0, a, K, 0, 1'b0);
        waitDrain();
        checkLogs("basic", 50, 110, 70, 50, 110, 70);

        applyStimulus(1'b0, a, K, 0, 1'b0);
        b = 0;
        while (!o_valid_r && b < 50) begin @(negedge clk); b++; end
        stall_left = 5;
        waitDrain();
        checkLogs("stall", 50, 110, 70, 50, 110, 70);

        applyStimulus(1'b0, a, K, 3, 1'b1);
        waitDrain();
        checkLogs("gaps", 50, 110, 70, 50, 110, 70);

        w = '{-1, -1, 0, 0, 0, 0};
        applyStimulus(1'b1, w, NK, 2, 1'b1);
        applyStimulus(1'b0, a, K, 0, 1'b0);
        waitDrain();
        checkLogs("relu_neg", 0, 0, 0, -30, 0, 0);

        w = '{32767, 32767, 32767, 32767, 32767, 32767};
        a = '{32767, 32767, 0, 0, 0, 0};
        applyStimulus(1'b1, w, NK, 0, 1'b0);
        applyStimulus(1'b0, a, K, 0, 1'b0);
        waitDrain();
        checkLogs("sat_pos", 32767, 32767, 32767, 32767, 32767, 32767);

        w = '{-32768, -32768, -32768, -32768, -32768, -32768};
        applyStimulus(1'b1, w, NK, 0, 1'b0);
        applyStimulus(1'b0, a, K, 0, 1'b0);
        waitDrain();
        checkLogs("sat_neg", 0, 0, 0, -32768, -32768, -32768);

        w = '{1, 2, 3, 4, -5, 6};
        a = '{10, 20, 0, 0, 0, 0};
        applyStimulus(1'b1, w, NK, 0, 1'b0);
        applyStimulus(1'b0, a, K, 0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        areset = 1'b1;
        for (int j = 0; j < NK; j++) model_w[j] = 0;
        exp_idx.delete(); exp_relu.delete(); exp_id.delete();
        timing_pending = 1'b0;
        @(posedge clk); #1;
        areset = 1'b0;
        @(negedge clk);
        resetChecks("midreset");
        repeat (20) @(posedge clk);
        #1;
        checkOutput("midreset_no_partial", log_relu.size(), 0);
        applyStimulus(1'b0, a, K, 0, 1'b0);
        waitDrain();
        checkLogs("after_reset", 0, 0, 0, 0, 0, 0);

        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            if (it == 0 || $urandom_range(1, 0) == 1) begin
                for (int j = 0; j < NK; j++) w[j] = rand_word();
                applyStimulus(1'b1, w, NK, 2, 1'b0);
            end
            for (int j = 0; j < NK; j++) a[j] = rand_word();
            applyStimulus(1'b0, a, K, 2, 1'b0);
            waitDrain();
            checkOutput("random_frame_count", log_relu.size(), N);
            log_relu.delete();
            log_id.delete();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
